// File: rtl/pm_loader_pkg.sv
// Shared definitions for the program-memory loader: FSM encoding and stream geometry.
package pm_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } pm_state_t;

  localparam int HDR_BYTES        = 2;
  localparam int BYTES_PER_WORD   = 4;
  localparam int PM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/pm_loader_word_assembler.sv
// Byte-to-word shift register, MSB first, with a wrapping byte index.
module pm_word_assembler
  import pm_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0] byte_idx;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], byte_in};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign last = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/pm_loader.sv
// Streams a length-prefixed, XOR-checksummed image into program memory while holding the CPU.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for start, CPU held
// LEN_HI   | accepting word-count high byte
// LEN_LO   | accepting word-count low byte, range check
// DATA     | accepting payload bytes into the assembler
// WRITE    | one-cycle program-memory write
// CHK      | accepting checksum byte and comparing
// DONE     | load good, CPU released
// ERR      | load aborted, CPU held
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int PM_DEPTH = PM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        pm_we,
  output logic [15:0] pm_addr,
  output logic [31:0] pm_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] DEPTH_L = 17'(PM_DEPTH);

  pm_state_t   state, state_nx;
  logic [15:0] word_cnt;
  logic [15:0] len_q;
  logic [7:0]  chk_q;
  logic        accept;
  logic        start_load;
  logic        asm_last;
  logic [15:0] len_n;
  logic [15:0] word_nx;

  assign accept     = byte_valid && byte_ready;
  assign start_load = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign len_n      = {len_q[15:8], byte_in};
  assign word_nx    = word_cnt + 16'd1;

  pm_word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_load),
    .shift_en (accept && (state == S_DATA)),
    .byte_in  (byte_in),
    .word     (pm_wdata),
    .last     (asm_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_LEN_HI;
      S_LEN_HI:              if (accept) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_n} > DEPTH_L) state_nx = S_ERR;
          else if (len_n == 16'd0)     state_nx = S_CHK;
          else                         state_nx = S_DATA;
        end
      end
      S_DATA:  if (asm_last) state_nx = S_WRITE;
      S_WRITE: state_nx = (word_nx == len_q) ? S_CHK : S_DATA;
      S_CHK: begin
        if (accept) state_nx = (byte_in == chk_q) ? S_DONE : S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    pm_we      = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: byte_ready = 1'b1;
      S_WRITE: pm_we = 1'b1;
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Word counter doubles as the write address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      len_q    <= '0;
      chk_q    <= '0;
    end else if (start_load) begin
      word_cnt <= '0;
      len_q    <= '0;
      chk_q    <= '0;
    end else begin
      if (accept && state != S_CHK) chk_q <= chk_q ^ byte_in;
      if (accept && state == S_LEN_HI) len_q[15:8] <= byte_in;
      if (accept && state == S_LEN_LO) len_q[7:0]  <= byte_in;
      if (state == S_WRITE) word_cnt <= word_nx;
    end
  end

  assign pm_addr = word_cnt;

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: good/bad checksum, oversize length, empty image, stalls, reset mid-load.
module tb_pm_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        pm_we;
  logic [15:0] pm_addr;
  logic [31:0] pm_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];

  logic [7:0] stream1 [11] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h46};

  pm_loader #(.PM_DEPTH(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_we) begin
      wr_addr.push_back(pm_addr);
      wr_data.push_back(pm_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_byte(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, {16'd0, wr_addr[0]}, 32'd0);
      check({tag, "_d0"}, wr_data[0], 32'h11223344);
      check({tag, "_a1"}, {16'd0, wr_addr[1]}, 32'd1);
      check({tag, "_d1"}, wr_data[1], 32'hA55A0FF0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold",  {31'd0, cpu_hold},   32'd1);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we",    {31'd0, pm_we},      32'd0);
    check("rst_addr",  {16'd0, pm_addr},    32'd0);
    check("rst_wdata", pm_wdata,            32'd0);
    check("rst_done",  {30'd0, done, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Good two-word image
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(stream1[i]);
    check("good_done",  {31'd0, done},     32'd1);
    check("good_err",   {31'd0, error},    32'd0);
    check("good_hold",  {31'd0, cpu_hold}, 32'd0);
    check_two_writes("good");

    // Corrupted checksum
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("restart_hold", {31'd0, cpu_hold}, 32'd1);
    check("restart_done", {31'd0, done},     32'd0);
    for (int i = 0; i < 10; i++) send_byte(stream1[i]);
    send_byte(8'h47);
    check("bad_err",  {31'd0, error},    32'd1);
    check("bad_done", {31'd0, done},     32'd0);
    check("bad_hold", {31'd0, cpu_hold}, 32'd1);
    check_two_writes("bad");

    // Length one over capacity
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h01);
    check("big_err",   {31'd0, error},      32'd1);
    check("big_ready", {31'd0, byte_ready}, 32'd0);
    check("big_nwr",   wr_addr.size(),      32'd0);

    // Empty image
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done", {31'd0, done},  32'd1);
    check("zero_nwr",  wr_addr.size(), 32'd0);

    // Stalled stream with a spurious start mid-load
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte_gap(stream1[i]);
    pulse_start();
    for (int i = 6; i < 11; i++) send_byte_gap(stream1[i]);
    check("stall_done", {31'd0, done}, 32'd1);
    check_two_writes("stall");

    // Reset after five bytes, then a fresh full load
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(stream1[i]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_hold",  {31'd0, cpu_hold},   32'd1);
    check("mid_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_we",    {31'd0, pm_we},      32'd0);
    check("mid_addr",  {16'd0, pm_addr},    32'd0);
    check("mid_wdata", pm_wdata,            32'd0);
    check("mid_flags", {30'd0, done, error}, 32'd0);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(stream1[i]);
    check("post_done", {31'd0, done}, 32'd1);
    check_two_writes("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pm_loader.md
PM_LOADER -- requirements
Module: pm_loader

Interface
REQ-001 Parameter: PM_DEPTH, default 1024, number of 32-bit words the program memory holds.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a new program load.
REQ-005 byte_in  input  8  incoming load-stream byte.
REQ-006 byte_valid  input  1  byte_in is valid this cycle.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-008 pm_we  output  1  program-memory write enable, one-cycle pulse per word.
REQ-009 pm_addr  output  16  program-memory word address for the write.
REQ-010 pm_wdata  output  32  program-memory write data.
REQ-011 cpu_hold  output  1  holds the processor's fetch path (reset/stall) while high.
REQ-012 done  output  1  load completed with a good checksum.
REQ-013 error  output  1  load aborted (length or checksum fault).

Function
REQ-014 Stream format: LEN_HI, LEN_LO (16-bit word count N), then N words of 4 bytes each, MSB first, then one CHK byte.
REQ-015 FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR.
REQ-016 IDLE/DONE/ERR: start=1 -> LEN_HI; clear the word counter, byte index, running checksum, done and error.
REQ-017 start is ignored in LEN_HI, LEN_LO, DATA, WRITE and CHK.
REQ-018 byte_ready is high in LEN_HI, LEN_LO, DATA and CHK, and low in every other state.
REQ-019 Each accepted byte, including length bytes and excluding CHK, is XORed into an 8-bit running checksum.
REQ-020 In LEN_LO, after the transfer: N > PM_DEPTH -> ERR; N = 0 -> CHK; otherwise -> DATA.
REQ-021 DATA: a 2-bit byte index shifts bytes into a 32-bit assembly register, MSB first; on the 4th byte -> WRITE.
REQ-022 WRITE lasts exactly one cycle with pm_we=1, pm_addr=word counter, pm_wdata=assembled word.
REQ-023 After WRITE the word counter increments; if it then equals N -> CHK, else -> DATA.
REQ-024 pm_addr increments from 0 to N-1 with no wrap; PM_DEPTH bounds N, so no overflow is possible.
REQ-025 CHK: if the accepted byte equals the running checksum -> DONE, else -> ERR.
REQ-026 pm_we is low in every state other than WRITE; pm_addr and pm_wdata are don't-care when pm_we is low but are driven as registers.
REQ-027 cpu_hold is high in every state except DONE.
REQ-028 done is high only in DONE; error is high only in ERR.
REQ-029 byte_valid while byte_ready is low is not consumed; the sender holds the byte.
REQ-030 An idle stream (byte_valid low) stalls the FSM indefinitely; no timeout.

Reset
REQ-031 reset=1 at a clock edge -> state IDLE, all counters and the checksum 0, pm_we=0, pm_addr=0, pm_wdata=0, done=0, error=0, cpu_hold=1, byte_ready=0.
REQ-032 reset takes priority over start and over any transfer in the same cycle.
REQ-033 reset during a load abandons the load; words already written are not undone.

Structure
REQ-034 A shared package holds the FSM state encoding, the header byte count (2), the bytes-per-word count (4) and the PM_DEPTH default.
REQ-035 One sub-module, pm_word_assembler (byte shift register plus byte index), is used; the rest of the logic is flat.

Verification
REQ-036 start; stream 00 02 | 11 22 33 44 | A5 5A 0F F0 | CHK=0x02^0x11^0x22^0x33^0x44^0xA5^0x5A^0x0F^0xF0 -> pm_we pulses at addr 0 data 0x11223344 and at addr 1 data 0xA55A0FF0; done=1; cpu_hold=0.
REQ-037 Same stream with CHK XORed with 0x01 -> both words written, then error=1, done=0, cpu_hold=1.
REQ-038 start; stream 04 01 with PM_DEPTH=1024 (N=1025) -> ERR immediately after LEN_LO; no pm_we pulse; byte_ready=0.
REQ-039 start; stream 00 00 then CHK=0x00 -> DONE with zero pm_we pulses.
REQ-040 byte_valid toggled randomly mid-word, plus start asserted mid-load -> identical writes to REQ-036; start has no effect.
REQ-041 reset asserted after the 5th byte of the REQ-036 stream -> next cycle IDLE with cpu_hold=1 and all other outputs 0; a fresh start and full stream then succeeds.
